// File: rtl/data_mem_if.sv
// data_mem_if -- load/store unit between an RV32I datapath and a simple
// request/acknowledge data memory.
//
// A legal, aligned load or store moves IDLE -> BUSY -> DONE -> IDLE. BUSY
// holds the word-aligned request until the memory acknowledges or the wait
// counter expires. DONE presents the extended load data for one cycle.
// Illegal or misaligned requests never reach memory; they raise oErr
// while the FSM stays in IDLE.
//
// Ports:
//   iClk, iRst       clock, synchronous active-low reset
//   iReq, iWe        access request, 1 = store / 0 = load
//   iFunct3          RV32I width code (B, H, W, BU, HU)
//   iAddr, iWrData   byte address and store data from the datapath
//   oRdData          aligned, extended load data (non-zero only in DONE)
//   oStall           holds the core while the access is pending
//   oErr             misaligned / illegal funct3 / timed-out access
//   oMem_*           memory request, write strobe, word address, byte enables,
//                    lane-replicated store data
//   iMem_Ack         memory completion; iMem_RdData is valid in the same cycle
module data_mem_if #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iReq,
    input  logic        iWe,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oStall,
    output logic        oErr,
    output logic        oMem_Req,
    output logic        oMem_We,
    output logic [31:0] oMem_Addr,
    output logic [3:0]  oMem_Be,
    output logic [31:0] oMem_WrData,
    input  logic        iMem_Ack,
    input  logic [31:0] iMem_RdData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r;
    logic [7:0]  cnt_r;
    logic        mem_req_r;
    logic        mem_we_r;
    logic [31:0] mem_addr_r;
    logic [3:0]  mem_be_r;
    logic [31:0] mem_wdata_r;
    logic        store_r;
    logic [1:0]  off_r;
    logic [2:0]  f3_r;
    logic        err_r;
    logic [31:0] rdata_r;

    logic        legal_f3_s;
    logic        aligned_s;
    logic        legal_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;

    // Select the byte/half lane named by the offset and extend it per funct3.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        byte_v = word[8*off +: 8];
        half_v = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res_v = {{24{byte_v[7]}}, byte_v};
            3'b001:  res_v = {{16{half_v[15]}}, half_v};
            3'b010:  res_v = word;
            3'b100:  res_v = {24'd0, byte_v};
            3'b101:  res_v = {16'd0, half_v};
            default: res_v = 32'd0;
        endcase
        return res_v;
    endfunction

    // Legality and alignment of the request presented by the core.
    always_comb begin
        legal_f3_s = 1'b0;
        aligned_s  = 1'b0;
        case (iFunct3)
            3'b000, 3'b100: begin
                legal_f3_s = 1'b1;
                aligned_s  = 1'b1;
            end
            3'b001, 3'b101: begin
                legal_f3_s = 1'b1;
                aligned_s  = ~iAddr[0];
            end
            3'b010: begin
                legal_f3_s = 1'b1;
                aligned_s  = (iAddr[1:0] == 2'b00);
            end
            default: begin
                legal_f3_s = 1'b0;
                aligned_s  = 1'b0;
            end
        endcase
    end

    assign legal_s = legal_f3_s & aligned_s;

    // Byte enables and lane-replicated store data for the request.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = iWrData;
        case (iFunct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << iAddr[1:0];
                wdata_s = {4{iWrData[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << iAddr[1:0];
                wdata_s = {2{iWrData[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = iWrData;
            end
        endcase
    end

    // Access FSM, wait counter and latched request/response state.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_r     <= IDLE;
            cnt_r       <= 8'd0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= 32'd0;
            mem_be_r    <= 4'd0;
            mem_wdata_r <= 32'd0;
            store_r     <= 1'b0;
            off_r       <= 2'd0;
            f3_r        <= 3'd0;
            err_r       <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (iReq && legal_s) begin
                        state_r     <= BUSY;
                        cnt_r       <= 8'd0;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= iWe;
                        mem_addr_r  <= {iAddr[31:2], 2'b00};
                        mem_be_r    <= be_s;
                        mem_wdata_r <= wdata_s;
                        store_r     <= iWe;
                        off_r       <= iAddr[1:0];
                        f3_r        <= iFunct3;
                        err_r       <= 1'b0;
                        rdata_r     <= 32'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (iMem_Ack) begin
                        state_r   <= DONE;
                        rdata_r   <= iMem_RdData;
                        err_r     <= 1'b0;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'd0;
                    end else if (cnt_r == TIMEOUT_C - 8'd1) begin
                        state_r   <= DONE;
                        rdata_r   <= 32'd0;
                        err_r     <= 1'b1;
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'd0;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Core-facing handshake: stall and error react in the request's first cycle.
    always_comb begin
        oStall  = iReq && legal_s && (state_r != DONE);
        oErr    = 1'b0;
        oRdData = 32'd0;
        case (state_r)
            IDLE: begin
                oErr = iReq && !legal_s;
            end
            DONE: begin
                oErr    = err_r;
                oRdData = store_r ? 32'd0 : load_extend(rdata_r, off_r, f3_r);
            end
            default: begin
                oErr    = 1'b0;
                oRdData = 32'd0;
            end
        endcase
    end

    assign oMem_Req    = mem_req_r;
    assign oMem_We     = mem_we_r;
    assign oMem_Addr   = mem_addr_r;
    assign oMem_Be     = mem_be_r;
    assign oMem_WrData = mem_wdata_r;

endmodule
